// File: rtl/mar_pkg.sv
// Shared types and helpers for the memory address register / burst sequencer.
package mar_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} mar_state_t;

  function automatic int len_w(input int mx);
    return $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/mar_beat_counter.sv
// Loadable beat down-counter; last flags the final outstanding beat of a burst.
module mar_beat_counter #(
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [LEN_W-1:0] count;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)                      count <= '0;
    else if (load)                 count <= load_val;
    else if (dec && count != '0)   count <= count - LEN_W'(1);
  end

  assign last = (count == LEN_W'(1));

endmodule

// File: rtl/mar_burst_unit.sv
// Memory address register with a req/ack burst sequencer stepping by STRIDE.
// Optional MAR_BOUNDS_CHECK_EN rejects bursts whose last address exceeds ADDR_LIMIT.
module mar_burst_unit
  import mar_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 9,
  parameter int MAX_BURST  = 16,
  parameter int STRIDE     = 1,
  parameter int ADDR_LIMIT = 511,
  localparam int LEN_W     = len_w(MAX_BURST)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              MARin,
  input  logic [DATA_W-1:0] bus,
  input  logic              burst_start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] q,
  output logic              mem_req,
  output logic              busy,
  output logic              done
`ifdef MAR_BOUNDS_CHECK_EN
  ,
  output logic              fault
`endif
);

  mar_state_t        state;
  logic [ADDR_W-1:0] q_eff;
  logic [LEN_W-1:0]  len_c;
  logic              beat, last, reject, start_ok;

  // A same-cycle MARin means the burst starts from the freshly loaded address.
  assign q_eff = MARin ? bus[ADDR_W-1:0] : q;
  assign len_c = (burst_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : burst_len;
  assign beat  = (state == ISSUE) && mem_ack;

`ifdef MAR_BOUNDS_CHECK_EN
  localparam int EW = ADDR_W + LEN_W + ADDR_W;
  logic [EW-1:0] end_addr;

  // Wide enough that the last address never wraps before comparison.
  assign end_addr = EW'(q_eff) + EW'(len_c - LEN_W'(1)) * EW'(STRIDE);
  assign reject   = (end_addr > EW'(ADDR_LIMIT));
`else
  localparam int unused_limit = ADDR_LIMIT;
  assign reject = 1'b0;
`endif

  assign start_ok = (state == IDLE) && burst_start && (len_c != '0) && !reject;

  generate
    if (DATA_W > ADDR_W) begin : g_bus_hi
      logic unused_bus_hi;
      assign unused_bus_hi = ^bus[DATA_W-1:ADDR_W];
    end
  endgenerate

  mar_beat_counter #(.LEN_W(LEN_W)) u_cnt (
    .clk      (clk),
    .clr      (clr),
    .load     (start_ok),
    .load_val (len_c),
    .dec      (beat),
    .last     (last)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      q     <= '0;
`ifdef MAR_BOUNDS_CHECK_EN
      fault <= 1'b0;
`endif
    end else begin
`ifdef MAR_BOUNDS_CHECK_EN
      fault <= (state == IDLE) && burst_start && (len_c != '0) && reject;
`endif
      case (state)
        IDLE: begin
          if (MARin) q <= bus[ADDR_W-1:0];
          if (burst_start && len_c == '0) state <= DONE;
          else if (start_ok)               state <= ISSUE;
        end
        ISSUE: begin
          if (mem_ack) begin
            q <= q + ADDR_W'(STRIDE);
            if (last) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_req = (state == ISSUE);
  assign busy    = (state == ISSUE) || (state == DONE);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_mar_burst_unit.sv
// Randomized bench for mar_burst_unit against a transaction-level address model.
module tb_mar_burst_unit;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 9;
  localparam int MAX_BURST  = 16;
  localparam int STRIDE     = 1;
  localparam int ADDR_LIMIT = 511;
  localparam int LEN_W      = 5;
  localparam int AMOD       = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              clr = 1'b0;
  logic              MARin = 1'b0;
  logic [DATA_W-1:0] bus = '0;
  logic              burst_start = 1'b0;
  logic [LEN_W-1:0]  burst_len = '0;
  logic              mem_ack = 1'b0;
  logic [ADDR_W-1:0] q;
  logic              mem_req, busy, done;
`ifdef MAR_BOUNDS_CHECK_EN
  logic              fault;
`endif

  int n_vec = 0;
  int n_err = 0;
  int mq    = 0;

  mar_burst_unit #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST),
    .STRIDE(STRIDE), .ADDR_LIMIT(ADDR_LIMIT)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .MARin       (MARin),
    .bus         (bus),
    .burst_start (burst_start),
    .burst_len   (burst_len),
    .mem_ack     (mem_ack),
    .q           (q),
    .mem_req     (mem_req),
    .busy        (busy),
    .done        (done)
`ifdef MAR_BOUNDS_CHECK_EN
    ,
    .fault       (fault)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Random bus noise that must be ignored while the unit is busy.
  task automatic noise;
    MARin       = 1'($urandom_range(1, 0));
    burst_start = 1'($urandom_range(1, 0));
    bus         = $urandom;
    burst_len   = LEN_W'($urandom);
  endtask

  task automatic quiet;
    MARin = 1'b0; burst_start = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic load_addr(input logic [31:0] v);
    MARin = 1'b1; bus = v; burst_start = 1'b0;
    mem_ack = 1'($urandom_range(1, 0));
    step;
    quiet;
    mq = int'(v[ADDR_W-1:0]);
    chk("load_q", 32'(q), mq);
    chk("load_busy", 32'({mem_req, busy, done}), 0);
  endtask

  task automatic run_burst(input bit ld, input logic [31:0] bv, input int len,
                           input int st_lo, input int st_hi);
    int base, n, exp_a, stalls;
    base = ld ? int'(bv[ADDR_W-1:0]) : mq;
    n    = (len > MAX_BURST) ? MAX_BURST : len;
    MARin = ld; bus = bv; burst_start = 1'b1; burst_len = LEN_W'(len); mem_ack = 1'b0;
    step;
    quiet;
    mq = base;
`ifdef MAR_BOUNDS_CHECK_EN
    if (n > 0 && base + (n - 1) * STRIDE > ADDR_LIMIT) begin
      chk("rej_fault", 32'(fault), 1);
      chk("rej_req", 32'(mem_req), 0);
      chk("rej_busy", 32'(busy), 0);
      chk("rej_q", 32'(q), base);
      step;
      chk("rej_fault_clr", 32'(fault), 0);
      chk("rej_req2", 32'(mem_req), 0);
      return;
    end
`endif
    if (n == 0) begin
      chk("zero_done", 32'(done), 1);
      chk("zero_req", 32'(mem_req), 0);
      chk("zero_busy", 32'(busy), 1);
      chk("zero_q", 32'(q), base);
      step;
      chk("zero_done_clr", 32'(done), 0);
      chk("zero_busy_clr", 32'(busy), 0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      exp_a  = (base + i * STRIDE) % AMOD;
      stalls = int'($urandom_range(st_hi, st_lo));
      for (int s = 0; s < stalls; s++) begin
        chk("stall_req", 32'(mem_req), 1);
        chk("stall_q", 32'(q), exp_a);
        noise;
        mem_ack = 1'b0;
        step;
        quiet;
      end
      chk("beat_req", 32'(mem_req), 1);
      chk("beat_q", 32'(q), exp_a);
      chk("beat_done", 32'(done), 0);
      noise;
      mem_ack = 1'b1;
      step;
      quiet;
    end
    mq = (base + n * STRIDE) % AMOD;
    chk("done_pulse", 32'(done), 1);
    chk("done_req", 32'(mem_req), 0);
    chk("done_busy", 32'(busy), 1);
    chk("done_q", 32'(q), mq);
    noise;
    mem_ack = 1'($urandom_range(1, 0));
    step;
    quiet;
    chk("post_done", 32'(done), 0);
    chk("post_busy", 32'({mem_req, busy}), 0);
    chk("post_q", 32'(q), mq);
  endtask

  initial begin
    #12;
    chk("rst_q", 32'(q), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clk);
    clr = 1'b1;
    step;

    load_addr(32'hFFFF_F0A5);
    load_addr(32'h0000_0010);
    run_burst(1'b0, 32'h0, 4, 0, 0);
    load_addr(32'h0000_0020);
    run_burst(1'b0, 32'h0, 2, 3, 3);
    load_addr(32'h0000_01FE);
    run_burst(1'b0, 32'h0, 4, 0, 0);
    run_burst(1'b1, 32'h0000_0040, 1, 0, 0);
    run_burst(1'b0, 32'h0, 0, 0, 0);
    load_addr(32'h0000_0100);
    run_burst(1'b0, 32'h0, 25, 0, 1);
    run_burst(1'b0, 32'h0, 3, 0, 0);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(1, 0) == 1) load_addr($urandom);
      run_burst(1'($urandom_range(1, 0)), $urandom, int'($urandom_range(20, 0)), 0, 2);
    end

    // Asynchronous reset in the middle of an 8-beat burst.
    load_addr(32'h0000_0050);
    MARin = 1'b0; burst_start = 1'b1; burst_len = LEN_W'(8);
    step;
    burst_start = 1'b0; mem_ack = 1'b1;
    repeat (3) step;
    #2 clr = 1'b0;
    #1;
    chk("arst_q", 32'(q), 0);
    chk("arst_req", 32'(mem_req), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    @(negedge clk);
    clr = 1'b1; mem_ack = 1'b0; mq = 0;
    step;
    chk("arst_idle_req", 32'(mem_req), 0);
    chk("arst_idle_q", 32'(q), 0);
    run_burst(1'b0, 32'h0, 2, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
